// File: rtl/capture_mem.sv
`default_nettype none
// ============================================================================
// Module   : capture_mem
// Purpose  : PCM sample capture engine. After a start pulse it discards a
//            programmable number of leading samples (sep), then writes the
//            next signal_len samples into an internal 2^aw x 16 RAM. The RAM
//            has an independent registered read port usable in every state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   pcm_clk       in   1    sole clock, rising edge
//   rst           in   1    asynchronous active-high reset
//   pcm_in_valid  in   1    upstream sample valid
//   pcm_in_ready  out  1    sample accepted this cycle (SKIP or CAPTURE)
//   pcm_in        in   16   PCM sample, two's complement
//   start         in   1    arms a capture (honoured in IDLE or DONE only)
//   sep           in   12   leading samples to discard
//   signal_len    in   aw   samples to store
//   busy          out  1    SKIP or CAPTURE
//   done          out  1    capture complete, held until next start
//   cap_cnt       out  aw   samples stored in current/last capture
//   rd_addr       in   aw   RAM read address
//   rd_data       out  16   RAM word, one-cycle registered latency
// ============================================================================
module capture_mem #(
  parameter int aw = 10
) (
  input  logic          pcm_clk,
  input  logic          rst,
  input  logic          pcm_in_valid,
  output logic          pcm_in_ready,
  input  logic [15:0]   pcm_in,
  input  logic          start,
  input  logic [11:0]   sep,
  input  logic [aw-1:0] signal_len,
  output logic          busy,
  output logic          done,
  output logic [aw-1:0] cap_cnt,
  input  logic [aw-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  localparam int c_depth = 1 << aw;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   sep_q, sep_d;
  logic [aw-1:0] len_q, len_d;
  logic [11:0]   skip_q, skip_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic [15:0]   rd_data_q;
  logic [15:0]   mem_q [c_depth];

  logic          w_xfer;
  logic          w_we;
  logic [11:0]   w_skip_inc;
  logic [aw-1:0] w_cnt_inc;

  // Ready is decoded from the registered state only, so it never depends
  // combinationally on pcm_in_valid.
  assign pcm_in_ready = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
  assign busy         = pcm_in_ready;
  assign done         = (state_q == ST_DONE);
  assign cap_cnt      = cnt_q;
  assign rd_data      = rd_data_q;

  assign w_xfer     = pcm_in_valid & pcm_in_ready;
  assign w_we       = w_xfer & (state_q == ST_CAPTURE);
  assign w_skip_inc = skip_q + 12'd1;
  assign w_cnt_inc  = cnt_q + {{(aw-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    sep_d   = sep_q;
    len_d   = len_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sep_d  = sep;
          len_d  = signal_len;
          skip_d = 12'd0;
          cnt_d  = '0;
          if (sep != 12'd0)
            state_d = ST_SKIP;
          else if (signal_len == '0)
            state_d = ST_DONE;
          else
            state_d = ST_CAPTURE;
        end
      end
      ST_SKIP: begin
        if (w_xfer) begin
          skip_d = w_skip_inc;
          if (w_skip_inc == sep_q)
            state_d = (len_q == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // cnt_q < len_q here, so the increment can never wrap.
        if (w_xfer) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == len_q)
            state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcm_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sep_q     <= 12'd0;
      len_q     <= '0;
      skip_q    <= 12'd0;
      cnt_q     <= '0;
      rd_data_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      sep_q     <= sep_d;
      len_q     <= len_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      // Non-blocking read alongside the write below gives old data on a
      // same-address collision.
      rd_data_q <= mem_q[rd_addr];
    end
  end

  // RAM array has no reset. Reset forces IDLE asynchronously, which
  // deasserts w_we, so an aborted capture writes nothing further.
  always_ff @(posedge pcm_clk) begin
    if (w_we)
      mem_q[cnt_q] <= pcm_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_mem
// Purpose  : Self-checking bench for capture_mem. A transaction-level model
//            tracks transfers since the last accepted start and derives the
//            expected handshake, status and RAM contents arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_mem;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          pcm_clk = 1'b0;
  logic          rst = 1'b1;
  logic          pcm_in_valid = 1'b0;
  logic          pcm_in_ready;
  logic [15:0]   pcm_in = 16'd0;
  logic          start = 1'b0;
  logic [11:0]   sep = 12'd0;
  logic [AW-1:0] signal_len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] cap_cnt;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;

  capture_mem #(.aw(AW)) dut (
    .pcm_clk      (pcm_clk),
    .rst          (rst),
    .pcm_in_valid (pcm_in_valid),
    .pcm_in_ready (pcm_in_ready),
    .pcm_in       (pcm_in),
    .start        (start),
    .sep          (sep),
    .signal_len   (signal_len),
    .busy         (busy),
    .done         (done),
    .cap_cnt      (cap_cnt),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 pcm_clk = ~pcm_clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus staged for the next cycle
  bit          s_valid = 1'b0;
  bit          s_start = 1'b0;
  logic [15:0] s_data = 16'd0;
  int          s_sep = 0;
  int          s_len = 0;
  int          s_raddr = 0;

  // Reference model: transfers counted since the last accepted start
  bit          m_armed = 1'b0;
  int          m_S = 0;
  int          m_L = 0;
  int          m_x = 0;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_rd = 16'd0;
  bit          m_rd_known = 1'b0;

  int obs_xfers = 0;
  bit last_done = 1'b0;

  function automatic bit m_ready();
    return m_armed && (m_x < m_S + m_L);
  endfunction

  function automatic int m_cnt();
    if (!m_armed) return 0;
    return (m_x > m_S) ? m_x - m_S : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rdy;
    bit xfer;
    rdy  = m_ready();
    xfer = s_valid && rdy;
    m_rd_known = m_known[s_raddr];
    m_rd       = m_mem[s_raddr];
    if (xfer) begin
      if (m_x >= m_S) begin
        m_mem[m_x - m_S]   = s_data;
        m_known[m_x - m_S] = 1'b1;
      end
      m_x++;
    end
    if (s_start && !rdy) begin
      m_armed = 1'b1;
      m_S = s_sep;
      m_L = s_len;
      m_x = 0;
    end
    s_start = 1'b0;
  endtask

  // One clock: drive staged inputs at negedge, check outputs, then advance model
  task automatic cyc();
    @(negedge pcm_clk);
    pcm_in_valid = s_valid;
    pcm_in       = s_data;
    start        = s_start;
    sep          = s_sep[11:0];
    signal_len   = s_len[AW-1:0];
    rd_addr      = s_raddr[AW-1:0];
    check("ready",   {31'd0, pcm_in_ready}, {31'd0, m_ready()});
    check("busy",    {31'd0, busy},         {31'd0, m_ready()});
    check("done",    {31'd0, done},         {31'd0, m_armed && !m_ready()});
    check("cap_cnt", {22'd0, cap_cnt},      m_cnt());
    if (m_rd_known) check("rd_data", {16'd0, rd_data}, {16'd0, m_rd});
    last_done = (done === 1'b1);
    if (pcm_in_valid && pcm_in_ready) obs_xfers++;
    @(posedge pcm_clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge pcm_clk);
    pcm_in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_ready",   {31'd0, pcm_in_ready}, 0);
    check("rst_busy",    {31'd0, busy},         0);
    check("rst_done",    {31'd0, done},         0);
    check("rst_cap_cnt", {22'd0, cap_cnt},      0);
    check("rst_rd_data", {16'd0, rd_data},      0);
    @(negedge pcm_clk);
    rst = 1'b0;
    pcm_in_valid = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_start = 1'b0;
    s_raddr = int'(rd_addr);
    m_armed = 1'b0;
    m_x = 0; m_S = 0; m_L = 0;
    m_rd = 16'd0;
    m_rd_known = 1'b1;
    @(posedge pcm_clk);
    model_edge();
  endtask

  task automatic arm(input int sp, input int ln);
    s_sep = sp; s_len = ln; s_start = 1'b1; s_valid = 1'b0;
    cyc();
    obs_xfers = 0;
  endtask

  task automatic sweep(input int first, input int last);
    s_valid = 1'b0;
    for (int a = first; a <= last; a++) begin
      s_raddr = a;
      cyc();
    end
    cyc();
  endtask

  typedef struct {
    int sp;
    int ln;
    bit gap;
    int exp_cnt;
    int exp_xfers;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d;
    int n;

    tbl[0] = '{sp: 3, ln: 5, gap: 1'b0, exp_cnt: 5, exp_xfers: 8};
    tbl[1] = '{sp: 0, ln: 4, gap: 1'b1, exp_cnt: 4, exp_xfers: 4};
    tbl[2] = '{sp: 0, ln: 0, gap: 1'b0, exp_cnt: 0, exp_xfers: 0};
    tbl[3] = '{sp: 2, ln: 0, gap: 1'b0, exp_cnt: 0, exp_xfers: 2};
    tbl[4] = '{sp: 0, ln: 1, gap: 1'b0, exp_cnt: 1, exp_xfers: 1};
    tbl[5] = '{sp: 7, ln: 3, gap: 1'b1, exp_cnt: 3, exp_xfers: 10};

    do_reset();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      arm(tbl[i].sp, tbl[i].ln);
      d = 0; n = 0;
      last_done = 1'b0;
      while (!last_done && n < 200) begin
        s_valid = tbl[i].gap ? (n % 2 == 0) : 1'b1;
        s_data  = d[15:0];
        if (s_valid) d++;
        cyc();
        n++;
      end
      check("tbl_done",    {31'd0, last_done}, 1);
      check("tbl_cap_cnt", {22'd0, cap_cnt},   tbl[i].exp_cnt);
      check("tbl_xfers",   obs_xfers,          tbl[i].exp_xfers);
      sweep(0, tbl[i].ln + 1);
    end

    // Start during CAPTURE with a different length is ignored
    arm(1, 6);
    s_valid = 1'b1;
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < 50) begin
      s_data = 16'h100 + n[15:0];
      if (n == 3) begin s_start = 1'b1; s_len = 2; s_sep = 0; end
      cyc();
      n++;
    end
    check("ign_done",    {31'd0, last_done}, 1);
    check("ign_cap_cnt", {22'd0, cap_cnt},   6);
    check("ign_xfers",   obs_xfers,          7);

    // Reset after two of six samples, then a fresh 3-sample capture
    arm(0, 6);
    s_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_data = 16'hA000 + k[15:0];
      cyc();
    end
    do_reset();
    arm(0, 3);
    s_valid = 1'b1;
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < 50) begin
      s_data = 16'hB000 + n[15:0];
      cyc();
      n++;
    end
    check("rst_new_cap_cnt", {22'd0, cap_cnt}, 3);
    sweep(0, 6);

    // Full depth, reading the address being written each cycle
    arm(0, DEPTH - 1);
    s_valid = 1'b1;
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < DEPTH + 50) begin
      s_data  = 16'($urandom);
      s_raddr = m_cnt();
      cyc();
      n++;
    end
    check("full_done",    {31'd0, last_done}, 1);
    check("full_cap_cnt", {22'd0, cap_cnt},   DEPTH - 1);
    sweep(0, DEPTH - 1);

    // Second short capture: same-address reads return the old words
    arm(0, 4);
    s_valid = 1'b1;
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < 50) begin
      s_data  = 16'($urandom);
      s_raddr = m_cnt();
      cyc();
      n++;
    end
    check("rbw_cap_cnt", {22'd0, cap_cnt}, 4);

    // Randomised traffic against the model
    for (int r = 0; r < 400; r++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 16'($urandom);
      s_start = ($urandom_range(0, 7) == 0);
      s_sep   = $urandom_range(0, 4);
      s_len   = $urandom_range(0, 6);
      s_raddr = $urandom_range(0, 7);
      cyc();
    end
    s_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
